fifo_ctrl_rx: RTL

- Single-clock FIFO controller that sequences the RX FIFO memory (DATASIZE x 2^ADDRSIZE, sync write, async read) in the I2C RX path.
- Generates write and read pointers, write enable, full/empty/count, threshold and error flags.
- The I2C shift engine pushes received bytes; the register/APB side pops them in show-ahead mode.
- Memory data does not pass through this block; only addresses and the write enable are driven.

---
 rtl/fifo_ctrl_rx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fifo_ctrl_rx.sv
// fifo_ctrl_rx: pointer, occupancy and flag controller for the I2C RX FIFO.
// Define FIFO_RX_FLUSH_EN to add the flush_i input.
module fifo_ctrl_rx #(
    parameter int ADDRSIZE  = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_en_i,
    input  logic                rd_en_i,
    input  logic                err_clr_i,
`ifdef FIFO_RX_FLUSH_EN
    input  logic                flush_i,
`endif
    output logic [ADDRSIZE-1:0] waddr_o,
    output logic [ADDRSIZE-1:0] raddr_o,
    output logic                wclken_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [ADDRSIZE:0]   count_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam int              DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] LP_ONE = (ADDRSIZE+1)'(1);
    localparam logic [ADDRSIZE:0] LP_AF  = (ADDRSIZE+1)'(AF_THRESH);
    localparam logic [ADDRSIZE:0] LP_AE  = (ADDRSIZE+1)'(AE_THRESH);

    logic [ADDRSIZE:0] r_wptr;
    logic [ADDRSIZE:0] r_rptr;
    logic [ADDRSIZE:0] r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_af;
    logic              r_ae;
    logic              r_ovf;
    logic              r_udf;

    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic [ADDRSIZE:0] w_wptr_nxt;
    logic [ADDRSIZE:0] w_rptr_nxt;
    logic [ADDRSIZE:0] w_count_nxt;
    logic              w_full_nxt;
    logic              w_empty_nxt;
    logic              w_af_nxt;
    logic              w_ae_nxt;
    logic              w_ovf_nxt;
    logic              w_udf_nxt;

`ifdef FIFO_RX_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    // A flush swallows any push or pop issued in the same cycle.
    assign w_push = wr_en_i & ~r_full  & ~w_flush;
    assign w_pop  = rd_en_i & ~r_empty & ~w_flush;

    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_udf_nxt   = r_udf;
        if (w_flush) begin
            w_rptr_nxt  = r_wptr;
            w_count_nxt = '0;
        end else begin
            if (w_push) begin
                w_wptr_nxt = r_wptr + LP_ONE;
            end
            if (w_pop) begin
                w_rptr_nxt = r_rptr + LP_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + LP_ONE;
                2'b01:   w_count_nxt = r_count - LP_ONE;
                default: w_count_nxt = r_count;
            endcase
            // A new error in the clearing cycle takes priority.
            w_ovf_nxt = (wr_en_i & r_full)  | (r_ovf & ~err_clr_i);
            w_udf_nxt = (rd_en_i & r_empty) | (r_udf & ~err_clr_i);
        end
    end

    always_comb begin
        w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
        w_full_nxt  = (w_wptr_nxt[ADDRSIZE] != w_rptr_nxt[ADDRSIZE]) &&
                      (w_wptr_nxt[ADDRSIZE-1:0] == w_rptr_nxt[ADDRSIZE-1:0]);
        w_af_nxt    = (w_count_nxt >= LP_AF);
        w_ae_nxt    = (w_count_nxt <= LP_AE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_full  <= w_full_nxt;
            r_empty <= w_empty_nxt;
            r_af    <= w_af_nxt;
            r_ae    <= w_ae_nxt;
            r_ovf   <= w_ovf_nxt;
            r_udf   <= w_udf_nxt;
        end
    end

    assign waddr_o        = r_wptr[ADDRSIZE-1:0];
    assign raddr_o        = r_rptr[ADDRSIZE-1:0];
    assign wclken_o       = w_push;
    assign full_o         = r_full;
    assign empty_o        = r_empty;
    assign count_o        = r_count;
    assign almost_full_o  = r_af;
    assign almost_empty_o = r_ae;
    assign overflow_o     = r_ovf;
    assign underflow_o    = r_udf;

    logic unused_depth;
    assign unused_depth = (DEPTH == 0);

endmodule
